runtime_check_unit: RTL and testbench
=====================================

Name: runtime_check_unit

Overview:
- Synthesizable self-check monitor for the risc_v_cpu core. Holds a table of expected architectural values keyed by instruction address.
- On each retired instruction it compares up to SLOTS expectations against the register bank, PC and data memory, and updates pass/fail counters.
- Captures the first failure and can halt the core.
- Sits beside the core on FPGA builds; benches reuse it as the checking engine.

Parameters:
- DATA_W, 32, width of compared values and PC
- DEPTH, 64, instruction table entries; index = pc[IDX_W+1:2], IDX_W = clog2(DEPTH)
- SLOTS, 4, expectations per instruction address
- CNT_W, 16, pass/fail counter width (saturating)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous: invalidate table, zero counters, clear flags and capture
- halt_on_fail  in  1  mode: stop checking and assert halted at first failure
- load_valid  in  1  expectation write request
- load_ready  out  1  high in IDLE only
- load_pc  in  DATA_W  instruction byte address
- load_target  in  7  0..31 = register x0..x31; 32 = PC; 64..127 = memory word target[5:0]; other values are illegal
- load_value  in  DATA_W  expected value
- retire_valid  in  1  one-cycle pulse: instruction at retire_pc has committed
- retire_pc  in  DATA_W  address of the committed instruction
- pc_value  in  DATA_W  current program_counter.pc_addr
- reg_rd_addr  out  5  register bank read address
- reg_rd_data  in  DATA_W  combinational read data
- mem_rd_addr  out  6  data memory word address
- mem_rd_data  in  DATA_W  combinational read data
- busy  out  1  check in progress; core must stall retirement
- halted  out  1  sticky failure halt
- pass_count, fail_count  out  CNT_W each  saturating counters
- fail_valid  out  1  first-failure record valid
- fail_pc, fail_expected, fail_actual  out  DATA_W each  first-failure record
- fail_target  out  7  first-failure target
- load_err  out  1  sticky: load dropped because of a full entry, out-of-range index or illegal target
- overrun  out  1  sticky: retire_valid seen while busy

Behaviour:
- Reset (reset=0, async) and clear: all slot valid bits 0, FSM IDLE, all outputs 0, except load_ready=1. Slot data is not reset.
- FSM states: IDLE, CHECK, HALT.
- Load (IDLE, load_valid & load_ready, sampled at clock):
  - Writes the lowest-numbered free slot of entry pc[IDX_W+1:2].
  - Dropped with load_err=1 if pc >= DEPTH*4, if all SLOTS of the entry are valid, or if the target is illegal.
  - Loads in the same cycle as a retire are accepted; retire has priority for the state transition.
- IDLE -> CHECK: retire_valid, retire_pc in range, and at least one valid slot at that entry. Latch the index and start at the lowest valid slot.
  - Out-of-range pc or an empty entry: no action, stay in IDLE.
- CHECK: one slot per cycle.
  - reg_rd_addr or mem_rd_addr is driven combinationally from the current slot's target (0 when unused).
  - actual = reg_rd_data, pc_value or mem_rd_data according to the target.
  - Register x0 is compared against reg_rd_data as returned, with no special-casing.
  - At the clock edge: a match increments pass_count; a mismatch increments fail_count. If fail_valid=0, the record (retire_pc, target, expected, actual) is captured and fail_valid is set.
  - Advance to the next valid slot. After the last one, go to IDLE; check latency = number of valid slots in the entry.
  - A mismatch with halt_on_fail=1 goes to HALT immediately; the remaining slots are skipped.
- busy = (state != IDLE). The core samples busy combinationally.
- retire_valid while in CHECK: overrun=1 and the retire is ignored.
- HALT: halted=1, busy=1, loads refused. Exits only via reset or clear.
- Counters saturate at all-ones. The capture record holds until reset or clear.
- clear has priority over load and retire in the same cycle.

Decomposition:
- Package risc_v_check_pkg holds:
  - state typedef (IDLE/CHECK/HALT)
  - target encoding constants: TGT_PC=32, TGT_MEM_BASE=64
  - function target_is_legal()
- Sub-module check_entry_table: DEPTH x SLOTS storage of {target, value}, per-slot valid flops, free-slot priority encoder, next-valid-slot finder.

Test Plan:
- Load x5=7 at pc 0x8; retire 0x8 with reg_rd_data=7 -> busy for 1 cycle, pass_count=1, fail_valid=0.
- Load three slots at pc 0x10 (x1=1, PC=0x14, mem[3]=0xDEAD); retire with matching inputs -> busy 3 cycles, reg_rd_addr=1 then mem_rd_addr=3, pass_count=3.
- halt_on_fail=1, slots x2=4 and x3=9 at pc 0x0, reg_rd_data=5 -> fail_count=1, fail record = (0x0, 2, 4, 5), halted=1, second slot not checked, pass_count=0.
- Five loads to one pc with SLOTS=4 -> fifth dropped, load_err=1; load_pc=DEPTH*4 -> dropped, load_err stays 1.
- Retire while busy -> overrun=1, counts unaffected. Assert reset=0 mid-CHECK -> busy=0 and counters=0 immediately (async); a later retire of that pc does nothing.
- Drive pass_count to all-ones via repeated matches -> one further match leaves it all-ones; clear -> counters 0, table empty.

Source files
------------

// File: rtl/risc_v_check_pkg.sv
// Shared types and target-encoding helpers for the runtime check unit.
package risc_v_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HALT
    } state_t;

    localparam logic [6:0] TGT_PC       = 7'd32;
    localparam logic [6:0] TGT_MEM_BASE = 7'd64;

    // Codes 33..63 fall between the PC slot and the memory window.
    function automatic logic target_is_legal(input logic [6:0] target);
        return (target <= TGT_PC) || (target >= TGT_MEM_BASE);
    endfunction

    function automatic logic target_is_mem(input logic [6:0] target);
        return target >= TGT_MEM_BASE;
    endfunction

endpackage

// File: rtl/check_entry_table.sv
// DEPTH x SLOTS expectation storage with per-slot valid bits, a free-slot
// allocator for writes and a valid-slot walker for the checking sequence.
module check_entry_table #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    parameter  int SLOTS  = 4,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [6:0]        i_wr_target,
    input  logic [DATA_W-1:0] i_wr_value,
    output logic              o_wr_full,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [SLOT_W-1:0] i_rd_slot,
    output logic [6:0]        o_rd_target,
    output logic [DATA_W-1:0] o_rd_value,
    output logic              o_any_valid,
    output logic [SLOT_W-1:0] o_first_slot,
    output logic              o_has_next,
    output logic [SLOT_W-1:0] o_next_slot
);

    logic [6:0]        r_tgt [DEPTH][SLOTS];
    logic [DATA_W-1:0] r_val [DEPTH][SLOTS];
    logic [SLOTS-1:0]  r_vld [DEPTH];

    logic [SLOTS-1:0]  w_wr_vld;
    logic [SLOTS-1:0]  w_rd_vld;
    logic [SLOT_W-1:0] w_free_slot;

    assign w_wr_vld    = r_vld[i_wr_idx];
    assign w_rd_vld    = r_vld[i_rd_idx];
    assign o_wr_full   = &w_wr_vld;
    assign o_any_valid = |w_rd_vld;
    assign o_rd_target = r_tgt[i_rd_idx][i_rd_slot];
    assign o_rd_value  = r_val[i_rd_idx][i_rd_slot];

    // Descending scans so the lowest matching slot is the one left standing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_free_slot = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!w_wr_vld[s]) w_free_slot = SLOT_W'(s);
        end
    end

    always_comb begin
        o_first_slot = '0;
        o_has_next   = 1'b0;
        o_next_slot  = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (w_rd_vld[s]) o_first_slot = SLOT_W'(s);
            if (w_rd_vld[s] && (s > int'(i_rd_slot))) begin
                o_has_next  = 1'b1;
                o_next_slot = SLOT_W'(s);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) r_vld[e] <= '0;
        end else if (i_clear) begin
            for (int e = 0; e < DEPTH; e++) r_vld[e] <= '0;
        end else if (i_wr_en) begin
            r_vld[i_wr_idx][w_free_slot] <= 1'b1;
        end
    end

    // NOTE: the payload array has no reset; the valid bits alone decide whether a slot means anything.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_tgt[i_wr_idx][w_free_slot] <= i_wr_target;
            r_val[i_wr_idx][w_free_slot] <= i_wr_value;
        end
    end

endmodule

// File: rtl/runtime_check_unit.sv
// Retirement-time self-check monitor: compares per-PC expectations against
// register bank, PC and data memory, keeps counters and a first-failure record.
module runtime_check_unit
    import risc_v_check_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int SLOTS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              halt_on_fail,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_pc,
    input  logic [6:0]        load_target,
    input  logic [DATA_W-1:0] load_value,
    input  logic              retire_valid,
    input  logic [DATA_W-1:0] retire_pc,
    input  logic [DATA_W-1:0] pc_value,
    output logic [4:0]        reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic [5:0]        mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_valid,
    output logic [DATA_W-1:0] fail_pc,
    output logic [DATA_W-1:0] fail_expected,
    output logic [DATA_W-1:0] fail_actual,
    output logic [6:0]        fail_target,
    output logic              load_err,
    output logic              overrun
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [DATA_W-1:0] PC_LIMIT = DATA_W'(DEPTH * 4);

    state_t            r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [SLOT_W-1:0] r_slot;
    logic [DATA_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_pass, r_fail;
    logic              r_fail_valid, r_load_err, r_overrun;
    logic [DATA_W-1:0] r_fail_pc, r_fail_exp, r_fail_act;
    logic [6:0]        r_fail_tgt;

    logic              w_idle, w_checking;
    logic [IDX_W-1:0]  w_retire_idx, w_rd_idx;
    logic              w_retire_in_range, w_load_ok, w_load_take, w_wr_en, w_load_drop;
    logic              w_wr_full, w_any_valid, w_has_next, w_start, w_match;
    logic [SLOT_W-1:0] w_first_slot, w_next_slot;
    logic [6:0]        w_cur_target;
    logic [DATA_W-1:0] w_cur_value, w_actual;

    assign w_idle            = (r_state == ST_IDLE);
    assign w_checking        = (r_state == ST_CHECK);
    assign w_retire_idx      = retire_pc[IDX_W+1:2];
    assign w_retire_in_range = (retire_pc < PC_LIMIT);
    assign w_rd_idx          = w_idle ? w_retire_idx : r_idx;

    // A load is only taken or refused while IDLE; clear wins over both.
    assign w_load_take = load_valid && w_idle && !clear;
    assign w_load_ok   = (load_pc < PC_LIMIT) && target_is_legal(load_target) && !w_wr_full;
    assign w_wr_en     = w_load_take && w_load_ok;
    assign w_load_drop = w_load_take && !w_load_ok;

    assign w_start = w_idle && retire_valid && w_retire_in_range && w_any_valid;

    check_entry_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SLOTS  (SLOTS)
    ) u_table (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (clear),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (load_pc[IDX_W+1:2]),
        .i_wr_target  (load_target),
        .i_wr_value   (load_value),
        .o_wr_full    (w_wr_full),
        .i_rd_idx     (w_rd_idx),
        .i_rd_slot    (r_slot),
        .o_rd_target  (w_cur_target),
        .o_rd_value   (w_cur_value),
        .o_any_valid  (w_any_valid),
        .o_first_slot (w_first_slot),
        .o_has_next   (w_has_next),
        .o_next_slot  (w_next_slot)
    );

    always_comb begin
        reg_rd_addr = '0;
        mem_rd_addr = '0;
        if (w_checking) begin
            if (target_is_mem(w_cur_target)) mem_rd_addr = w_cur_target[5:0];
            else if (w_cur_target != TGT_PC) reg_rd_addr = w_cur_target[4:0];
        end
    end

    // Kept apart from the address mux: read data returns through the core combinationally.
    always_comb begin
        w_actual = reg_rd_data;
        if (target_is_mem(w_cur_target)) w_actual = mem_rd_data;
        else if (w_cur_target == TGT_PC) w_actual = pc_value;
    end

    assign w_match = (w_actual == w_cur_value);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_CHECK;
            ST_CHECK: begin
                if (!w_match && halt_on_fail) w_next = ST_HALT;
                else if (!w_has_next)         w_next = ST_IDLE;
            end
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_IDLE;
        endcase
        if (clear) w_next = ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || clear) begin
            r_idx        <= '0;
            r_slot       <= '0;
            r_pc         <= '0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_fail_valid <= 1'b0;
            r_fail_pc    <= '0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
            r_fail_tgt   <= '0;
            r_load_err   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx  <= w_retire_idx;
                r_slot <= w_first_slot;
                r_pc   <= retire_pc;
            end
            if (w_checking) begin
                r_slot <= w_next_slot;
                if (w_match) begin
                    if (r_pass != '1) r_pass <= r_pass + 1'b1;
                end else begin
                    if (r_fail != '1) r_fail <= r_fail + 1'b1;
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_pc    <= r_pc;
                        r_fail_tgt   <= w_cur_target;
                        r_fail_exp   <= w_cur_value;
                        r_fail_act   <= w_actual;
                    end
                end
            end
            if (retire_valid && !w_idle) r_overrun  <= 1'b1;
            if (w_load_drop)             r_load_err <= 1'b1;
        end
    end

    assign load_ready    = w_idle;
    assign busy          = !w_idle;
    assign halted        = (r_state == ST_HALT);
    assign pass_count    = r_pass;
    assign fail_count    = r_fail;
    assign fail_valid    = r_fail_valid;
    assign fail_pc       = r_fail_pc;
    assign fail_target   = r_fail_tgt;
    assign fail_expected = r_fail_exp;
    assign fail_actual   = r_fail_act;
    assign load_err      = r_load_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_runtime_check_unit.sv
// Self-checking bench for runtime_check_unit: table model plus per-slot scoreboard.
module tb_runtime_check_unit;

    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [6:0]    tgt;
        logic [DW-1:0] val;
        logic [DW-1:0] act;
    } item_t;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, halt_on_fail = 1'b0;
    logic load_valid = 1'b0, retire_valid = 1'b0;
    logic [DW-1:0] load_pc = '0, load_value = '0, retire_pc = '0, tb_pc = '0;
    logic [6:0] load_target = '0;
    logic load_ready, busy, halted, fail_valid, load_err, overrun;
    logic [4:0] reg_rd_addr;
    logic [5:0] mem_rd_addr;
    logic [DW-1:0] reg_rd_data, mem_rd_data, fail_pc, fail_expected, fail_actual;
    logic [6:0] fail_target;
    logic [CW-1:0] pass_count, fail_count;

    logic [DW-1:0] tb_regs [32];
    logic [DW-1:0] tb_mem  [64];
    assign reg_rd_data = tb_regs[reg_rd_addr];
    assign mem_rd_data = tb_mem[mem_rd_addr];

    runtime_check_unit #(.DATA_W(DW), .DEPTH(64), .SLOTS(4), .CNT_W(CW)) dut (
        .clock(clk), .reset(rst_n), .clear(clear), .halt_on_fail(halt_on_fail),
        .load_valid(load_valid), .load_ready(load_ready), .load_pc(load_pc),
        .load_target(load_target), .load_value(load_value),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .pc_value(tb_pc),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .halted(halted), .pass_count(pass_count), .fail_count(fail_count),
        .fail_valid(fail_valid), .fail_pc(fail_pc), .fail_expected(fail_expected),
        .fail_actual(fail_actual), .fail_target(fail_target),
        .load_err(load_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model of the table and of the observable status.
    int          m_cnt [64];
    logic [6:0]  m_tgt [64][4];
    logic [DW-1:0] m_val [64][4];
    int exp_pass, exp_fail;
    logic exp_fv, exp_halted, exp_load_err, exp_overrun;
    logic [DW-1:0] exp_fpc, exp_fexp, exp_fact;
    logic [6:0] exp_ftgt;
    item_t sb_q [$];

    task automatic model_reset();
        for (int e = 0; e < 64; e++) m_cnt[e] = 0;
        exp_pass = 0; exp_fail = 0; exp_fv = 0; exp_halted = 0;
        exp_load_err = 0; exp_overrun = 0;
        exp_fpc = '0; exp_fexp = '0; exp_fact = '0; exp_ftgt = '0;
        sb_q.delete();
    endtask

    task automatic model_load(input logic [DW-1:0] pc, input logic [6:0] t, input logic [DW-1:0] v);
        int idx;
        idx = int'(pc[7:2]);
        if (pc >= 32'd256 || (t > 7'd32 && t < 7'd64) || m_cnt[idx] == 4) begin
            exp_load_err = 1'b1;
        end else begin
            m_tgt[idx][m_cnt[idx]] = t;
            m_val[idx][m_cnt[idx]] = v;
            m_cnt[idx]++;
        end
    endtask

    function automatic logic [DW-1:0] env_actual(input logic [6:0] t);
        if (t < 7'd32)  return tb_regs[t[4:0]];
        if (t == 7'd32) return tb_pc;
        return tb_mem[t[5:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] pc, input logic [6:0] t, input logic [DW-1:0] v);
        load_valid = 1'b1; load_pc = pc; load_target = t; load_value = v;
        model_load(pc, t, v);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        checks++; if (pass_count !== '0 || fail_count !== '0) begin failures++;
            $display("FAIL clear_counters: pass=%0d fail=%0d required 0/0", pass_count, fail_count); end
        checks++; if ({busy, halted, fail_valid, load_err, overrun, load_ready} !== 6'b000001) begin failures++;
            $display("FAIL clear_flags: busy/halted/fv/lerr/ovr/ready=%b required 000001",
                     {busy, halted, fail_valid, load_err, overrun, load_ready}); end
    endtask

    // Pushes one scoreboard item per slot the DUT should visit, then pops one per busy cycle.
    task automatic do_retire(input string name, input logic [DW-1:0] pc, input bit overlap);
        int idx, n_exp, cycles;
        item_t it;
        logic [4:0] e_reg;
        logic [5:0] e_mem;
        idx = int'(pc[7:2]);
        n_exp = 0;
        if (pc < 32'd256) begin
            for (int s = 0; s < m_cnt[idx]; s++) begin
                it = '{tgt: m_tgt[idx][s], val: m_val[idx][s], act: env_actual(m_tgt[idx][s])};
                sb_q.push_back(it);
                n_exp++;
                if (it.act != it.val && halt_on_fail) break;
            end
        end
        if (overlap && n_exp > 0) exp_overrun = 1'b1;
        retire_pc = pc; retire_valid = 1'b1;
        tick();
        retire_valid = overlap; load_valid = 1'b0;
        cycles = 0;
        while (busy && !halted && cycles < 20) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s_extra_cycle: busy in cycle %0d, required idle", name, cycles);
            end else begin
                it = sb_q.pop_front();
                e_reg = (it.tgt < 7'd32) ? it.tgt[4:0] : 5'd0;
                e_mem = (it.tgt >= 7'd64) ? it.tgt[5:0] : 6'd0;
                checks++; if (reg_rd_addr !== e_reg || mem_rd_addr !== e_mem) begin failures++;
                    $display("FAIL %s_rd_addr: reg=%0d mem=%0d required reg=%0d mem=%0d",
                             name, reg_rd_addr, mem_rd_addr, e_reg, e_mem); end
                if (it.act == it.val) begin
                    if (exp_pass != CNT_MAX) exp_pass++;
                end else begin
                    if (exp_fail != CNT_MAX) exp_fail++;
                    if (!exp_fv) begin
                        exp_fv = 1'b1; exp_fpc = pc; exp_ftgt = it.tgt;
                        exp_fexp = it.val; exp_fact = it.act;
                    end
                    if (halt_on_fail) exp_halted = 1'b1;
                end
            end
            tick();
            retire_valid = 1'b0;
            cycles++;
        end
        retire_valid = 1'b0;
        checks++; if (cycles != n_exp || sb_q.size() != 0) begin failures++;
            $display("FAIL %s_latency: busy %0d cycles, required %0d", name, cycles, n_exp); end
        sb_q.delete();
        checks++; if (int'(pass_count) != exp_pass || int'(fail_count) != exp_fail) begin failures++;
            $display("FAIL %s_counts: pass=%0d fail=%0d required %0d/%0d",
                     name, pass_count, fail_count, exp_pass, exp_fail); end
        checks++; if (halted !== exp_halted || busy !== exp_halted || fail_valid !== exp_fv || overrun !== exp_overrun) begin
            failures++;
            $display("FAIL %s_status: halted=%b busy=%b fv=%b ovr=%b required %b/%b/%b/%b",
                     name, halted, busy, fail_valid, overrun, exp_halted, exp_halted, exp_fv, exp_overrun); end
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({busy, halted, fail_valid, load_err, overrun, load_ready} !== 6'b000001) begin failures++;
            $display("FAIL reset_flags: busy/halted/fv/lerr/ovr/ready=%b required 000001",
                     {busy, halted, fail_valid, load_err, overrun, load_ready}); end
        checks++; if (pass_count !== '0 || fail_count !== '0 || fail_pc !== '0) begin failures++;
            $display("FAIL reset_counters: pass=%0d fail=%0d fail_pc=%h required 0", pass_count, fail_count, fail_pc); end
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        tb_regs[5] = 32'd7;
        do_load(32'h8, 7'd5, 32'd7);
        do_retire("single", 32'h8, 1'b0);
    endtask

    task automatic test_multi();
        tb_regs[1] = 32'd1; tb_pc = 32'h14; tb_mem[3] = 32'hDEAD;
        do_load(32'h10, 7'd1, 32'd1);
        do_load(32'h10, 7'd32, 32'h14);
        do_load(32'h10, 7'd67, 32'hDEAD);
        do_retire("multi", 32'h10, 1'b0);
    endtask

    task automatic test_halt();
        do_clear();
        halt_on_fail = 1'b1;
        tb_regs[2] = 32'd5; tb_regs[3] = 32'd9;
        do_load(32'h0, 7'd2, 32'd4);
        do_load(32'h0, 7'd3, 32'd9);
        do_retire("halt", 32'h0, 1'b0);
        checks++; if (fail_pc !== exp_fpc || fail_target !== exp_ftgt || fail_expected !== exp_fexp || fail_actual !== exp_fact) begin
            failures++;
            $display("FAIL halt_record: pc=%h tgt=%0d exp=%0d act=%0d required %h/%0d/%0d/%0d",
                     fail_pc, fail_target, fail_expected, fail_actual, exp_fpc, exp_ftgt, exp_fexp, exp_fact); end
        tick();
        checks++; if (load_ready !== 1'b0 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_sticky: load_ready=%b halted=%b required 0/1", load_ready, halted); end
        halt_on_fail = 1'b0;
        do_clear();
    endtask

    task automatic test_load_err();
        for (int i = 1; i <= 5; i++) begin
            tb_regs[i] = 32'(i * 3);
            do_load(32'h20, 7'(i), 32'(i * 3));
            if (i == 4) begin
                checks++; if (load_err !== 1'b0) begin failures++;
                    $display("FAIL load_err_early: load_err=%b required 0 after 4 loads", load_err); end
            end
        end
        checks++; if (load_err !== 1'b1) begin failures++;
            $display("FAIL load_err_full: load_err=%b required 1", load_err); end
        do_load(32'd256, 7'd1, 32'd0);
        checks++; if (load_err !== exp_load_err) begin failures++;
            $display("FAIL load_err_range: load_err=%b required %b", load_err, exp_load_err); end
        do_retire("full_entry", 32'h20, 1'b0);
        do_retire("out_of_range", 32'd256, 1'b0);
        do_clear();
        do_load(32'h24, 7'd40, 32'd0);
        checks++; if (load_err !== exp_load_err) begin failures++;
            $display("FAIL load_err_illegal: load_err=%b required %b", load_err, exp_load_err); end
        do_retire("illegal_entry", 32'h24, 1'b0);
        do_clear();
    endtask

    task automatic test_overrun();
        tb_regs[8] = 32'd80; tb_regs[9] = 32'd91;
        do_load(32'h30, 7'd8, 32'd80);
        do_load(32'h30, 7'd9, 32'd90);
        do_retire("overrun", 32'h30, 1'b1);
    endtask

    task automatic test_load_with_retire();
        tb_regs[5] = 32'd7; tb_regs[10] = 32'hA5;
        do_load(32'h8, 7'd5, 32'd7);
        load_valid = 1'b1; load_pc = 32'h50; load_target = 7'd10; load_value = 32'hA5;
        model_load(32'h50, 7'd10, 32'hA5);
        do_retire("concurrent", 32'h8, 1'b0);
        do_retire("loaded_during_retire", 32'h50, 1'b0);
    endtask

    task automatic test_async_reset();
        do_clear();
        tb_regs[6] = 32'd1; tb_regs[7] = 32'd2;
        do_load(32'h40, 7'd6, 32'd1);
        do_load(32'h40, 7'd7, 32'd2);
        retire_pc = 32'h40; retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        tick();
        checks++; if (pass_count !== 4'd1 || busy !== 1'b1) begin failures++;
            $display("FAIL mid_check: pass=%0d busy=%b required 1/1", pass_count, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || pass_count !== '0 || load_ready !== 1'b1) begin failures++;
            $display("FAIL async_reset: busy=%b pass=%0d ready=%b required 0/0/1", busy, pass_count, load_ready); end
        tick();
        rst_n = 1'b1;
        model_reset();
        do_retire("after_reset", 32'h40, 1'b0);
    endtask

    task automatic test_saturation();
        do_clear();
        tb_regs[5] = 32'd7;
        do_load(32'h8, 7'd5, 32'd7);
        for (int i = 0; i < CNT_MAX + 1; i++) do_retire("saturate", 32'h8, 1'b0);
        checks++; if (pass_count !== 4'hF) begin failures++;
            $display("FAIL saturation: pass=%0d required %0d", pass_count, CNT_MAX); end
        do_clear();
        do_retire("cleared_table", 32'h8, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tb_regs[i] = 32'(i) ^ 32'h5A5A0000;
        for (int i = 0; i < 64; i++) tb_mem[i]  = 32'(i) ^ 32'hC3C30000;
        test_reset();
        test_single();
        test_multi();
        test_halt();
        test_load_err();
        test_overrun();
        test_load_with_retire();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
